store_seq: RTL and testbench
============================

Name: store_seq

Overview:
Multi-cycle store sequencer for the memory write-data path. It drives the select of the write-data mux: 0 selects the merged word (WC), 1 selects register B. For sw it writes B directly. For sh/sb it reads the target word, merges the sub-word lane into it to build WC, then writes WC back. It sits between the main control FSM and the memory and write-data mux, and reports busy/done/err to the main FSM.

Parameters:
MEM_LAT, 1, memory read latency in cycles; legal values are 1 or greater.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous reset, active-low (asserted when 0)
start  input  1  store request; sampled only in IDLE
store_type  input  2  00=sw, 01=sh, 10=sb, 11=illegal
addr_lo  input  2  byte address bits [1:0] of the store
b_data  input  32  register B value
mem_rdata  input  32  memory read data
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
WriteDataCtrl  output  1  write-data mux select (0=WC, 1=B)
wc_word  output  32  merged word register (WC), feeds mux input 0
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle illegal/misaligned pulse, coincident with done

Behaviour:
- Reset (reset==0 at clock edge):
  - State goes to IDLE.
  - All outputs are 0, including wc_word=0.
  - Applies mid-operation too: any pending write is abandoned and mem_wr is never asserted after reset.
- IDLE:
  - When start==1, latch store_type, addr_lo and b_data. Later changes on these inputs are ignored until the next IDLE.
  - Next state: sw → WRITE_B; sh/sb → READ; illegal or misaligned → ERR.
  - start while busy==1 is ignored; there is no queuing.
- READ:
  - mem_rd=1 for exactly MEM_LAT cycles, tracked by an internal counter that is cleared on entry.
  - Then go to MERGE.
- MERGE:
  - mem_rdata must be valid in this cycle.
  - On the edge ending the cycle, wc_word <= mem_rdata with the lane replaced.
  - sb: byte lane addr_lo, i.e. bits [8*addr_lo+7 : 8*addr_lo] <= b_data[7:0].
  - sh: half lane addr_lo[1], i.e. bits [16*addr_lo[1]+15 : 16*addr_lo[1]] <= b_data[15:0].
  - All other bits are kept from mem_rdata.
  - Next state: WRITE_WC.
- WRITE_WC: mem_wr=1, WriteDataCtrl=0, for one cycle → DONE.
- WRITE_B: mem_wr=1, WriteDataCtrl=1, for one cycle → DONE. wc_word is unchanged.
- DONE: done=1 for one cycle → IDLE.
- ERR: done=1, err=1 for one cycle → IDLE. No mem_rd or mem_wr is issued.
- WriteDataCtrl is 1 only in WRITE_B; it is 0 in every other state.
- wc_word holds its value between operations.
- Latency, measured from the start cycle = cycle 0:
  - sw: mem_wr in cycle 1, done in cycle 2.
  - sh/sb: mem_rd in cycles 1..MEM_LAT, MERGE in cycle MEM_LAT+1, mem_wr in cycle MEM_LAT+2, done in cycle MEM_LAT+3.
- Back-to-back operation: start may be asserted in the cycle after done, because the FSM is in IDLE then.

Optional Feature:
STORE_SEQ_ALIGN_CHECK_EN:
- Defined: sw with addr_lo!=00, or sh with addr_lo[0]==1, goes to ERR.
- Undefined: the misalignment check is removed and err stays 0 except for store_type 11.
  - sw ignores addr_lo.
  - sh uses lane addr_lo[1] and ignores addr_lo[0].
- store_type 11 always goes to ERR, with or without the macro.

Test Plan:
- sw, b_data=0xDEADBEEF, addr_lo=0 → cycle 1: mem_wr=1, WriteDataCtrl=1; cycle 2: done=1; mem_rd never asserted.
- sb, MEM_LAT=1, b_data=0x000000AB, addr_lo=2, mem_rdata=0x11223344 → mem_rd in cycle 1; wc_word=0x11AB3344 after MERGE; cycle 3: mem_wr=1, WriteDataCtrl=0; cycle 4: done=1.
- sh, MEM_LAT=3, b_data=0x0000BEEF, addr_lo=2, mem_rdata=0x11223344 → mem_rd in cycles 1–3; wc_word=0xBEEF3344; mem_wr in cycle 5; done in cycle 6.
- sh, addr_lo=1, mem_rdata=0x11223344:
  - With the macro: cycle 1 has done=1 and err=1; no mem_rd or mem_wr.
  - Without the macro: wc_word=0x1122BEEF and the write completes normally.
- Reset=0 asserted during READ of an sb → next cycle: IDLE, all outputs 0, no mem_wr ever issued; a following sw then completes normally.
- start pulsed again during WRITE_WC with store_type=00 → ignored; exactly one done pulse; busy returns to 0 after DONE.

Source files
------------

// File: rtl/store_seq.sv
// Store sequencer: sw writes B directly; sh/sb read the word, merge the lane into WC, write WC back.
// Optional `STORE_SEQ_ALIGN_CHECK_EN routes misaligned sw/sh to ERR.
module store_seq_lane #(
  parameter int LANE_W = 8
) (
  input  logic              en,
  input  logic [LANE_W-1:0] old_b,
  input  logic [LANE_W-1:0] new_b,
  output logic [LANE_W-1:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module store_seq #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        WriteDataCtrl,
  output logic [31:0] wc_word,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  typedef enum logic [2:0] {
    IDLE, READ, MERGE, WRITE_WC, WRITE_B, DONE, ERR
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    addr_q, addr_d;
  logic [15:0]   b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wc_q, wc_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          wdc_q, wdc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          bad_req;

  // Only the low half of B can land in a sub-word lane; the full word goes out via the mux.
  logic unused_b_hi;
  assign unused_b_hi = ^b_data[31:16];

`ifdef STORE_SEQ_ALIGN_CHECK_EN
  assign bad_req = (store_type == ST_ILL) ||
                   ((store_type == ST_SW) && (addr_lo != 2'b00)) ||
                   ((store_type == ST_SH) && addr_lo[0]);
`else
  assign bad_req = (store_type == ST_ILL);
`endif

  logic [NUM_LANES-1:0]             lane_en;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_old, lane_src, lane_out;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_en[i]  = (type_q == ST_SB) ? (addr_q == 2'(i))
                                           : ((type_q == ST_SH) && (addr_q[1] == 1'(i / 2)));
    assign lane_src[i] = (type_q == ST_SH) ? b_q[LANE_W*(i%2) +: LANE_W] : b_q[LANE_W-1:0];
    assign lane_old[i] = mem_rdata[LANE_W*i +: LANE_W];
    store_seq_lane #(.LANE_W(LANE_W)) u_lane (
      .en    (lane_en[i]),
      .old_b (lane_old[i]),
      .new_b (lane_src[i]),
      .out_b (lane_out[i])
    );
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          type_d = store_type;
          addr_d = addr_lo;
          b_d    = b_data[15:0];
          cnt_d  = '0;
          if (bad_req)                 state_d = ERR;
          else if (store_type == ST_SW) state_d = WRITE_B;
          else                          state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) state_d = MERGE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      MERGE: begin
        wc_d    = lane_out;
        state_d = WRITE_WC;
      end
      WRITE_WC, WRITE_B: state_d = DONE;
      DONE, ERR:         state_d = IDLE;
      default:           state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    mem_rd_d = (state_d == READ);
    mem_wr_d = (state_d == WRITE_WC) || (state_d == WRITE_B);
    wdc_d    = (state_d == WRITE_B);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE) || (state_d == ERR);
    err_d    = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      type_q   <= '0;
      addr_q   <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      wc_q     <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      wdc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      wc_q     <= wc_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      wdc_q    <= wdc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign WriteDataCtrl = wdc_q;
  assign wc_word       = wc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_store_seq.sv
// Randomized bench for store_seq: two instances (MEM_LAT=1 and 3) share stimulus and are
// compared cycle by cycle against a latency/merge model derived from the store rules.
module tb_store_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start1, start3;
  logic [1:0]  store_type, addr_lo;
  logic [31:0] b_data, mem_rdata;
  logic        rd1, wr1, wdc1, busy1, done1, err1;
  logic        rd3, wr3, wdc3, busy3, done3, err3;
  logic [31:0] wc1, wc3;

`ifdef STORE_SEQ_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  store_seq #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .store_type(store_type), .addr_lo(addr_lo),
    .b_data(b_data), .mem_rdata(mem_rdata), .mem_rd(rd1), .mem_wr(wr1),
    .WriteDataCtrl(wdc1), .wc_word(wc1), .busy(busy1), .done(done1), .err(err1));

  store_seq #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .store_type(store_type), .addr_lo(addr_lo),
    .b_data(b_data), .mem_rdata(mem_rdata), .mem_rd(rd3), .mem_wr(wr3),
    .WriteDataCtrl(wdc3), .wc_word(wc3), .busy(busy3), .done(done3), .err(err3));

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] wc_m1 = '0;
  logic [31:0] wc_m3 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // op class: 0 = error, 1 = sw, 2 = read-modify-write
  function automatic int op_class(input logic [1:0] t, input logic [1:0] a);
    if (t == 2'b11) return 0;
    if (ALIGN && ((t == 2'b00 && a != 2'b00) || (t == 2'b01 && a[0]))) return 0;
    return (t == 2'b00) ? 1 : 2;
  endfunction

  // expected {mem_rd, mem_wr, WriteDataCtrl, busy, done, err} in cycle k after start
  function automatic logic [5:0] exp_ctl(input int cls, input int lat, input int k);
    if (cls == 0) return (k == 1) ? 6'b000111 : 6'b000000;
    if (cls == 1) begin
      if (k == 1) return 6'b011100;
      if (k == 2) return 6'b000110;
      return 6'b000000;
    end
    if (k >= 1 && k <= lat) return 6'b100100;
    if (k == lat + 1) return 6'b000100;
    if (k == lat + 2) return 6'b010100;
    if (k == lat + 3) return 6'b000110;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] merge(input logic [1:0] t, input logic [1:0] a,
                                        input logic [31:0] b, input logic [31:0] m);
    int sh;
    logic [31:0] mask;
    if (t == 2'b10) begin
      sh = 8 * a;
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * a[1];
      mask = 32'hFFFF << sh;
    end
    return (m & ~mask) | ((b << sh) & mask);
  endfunction

  function automatic int lat_done(input int cls, input int lat);
    return (cls == 0) ? 1 : (cls == 1) ? 2 : lat + 3;
  endfunction

  task automatic run_op(input logic [1:0] t, input logic [1:0] a, input logic [31:0] b,
                        input logic [31:0] m, input bit hold);
    int cls = op_class(t, a);
    int n1 = lat_done(cls, 1);
    int n3 = lat_done(cls, 3);
    logic [31:0] new_wc = merge(t, a, b, m);
    @(negedge clk);
    chk("idle1", {58'd0, rd1, wr1, wdc1, busy1, done1, err1}, 64'd0);
    chk("idle3", {58'd0, rd3, wr3, wdc3, busy3, done3, err3}, 64'd0);
    start1 = 1'b1; start3 = 1'b1;
    store_type = t; addr_lo = a; b_data = b; mem_rdata = m;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("ctl1 t%0d a%0d k%0d", t, a, k),
          {58'd0, rd1, wr1, wdc1, busy1, done1, err1}, {58'd0, exp_ctl(cls, 1, k)});
      chk($sformatf("wc1 k%0d", k), {32'd0, wc1},
          {32'd0, (cls == 2 && k >= 3) ? new_wc : wc_m1});
      chk($sformatf("ctl3 t%0d a%0d k%0d", t, a, k),
          {58'd0, rd3, wr3, wdc3, busy3, done3, err3}, {58'd0, exp_ctl(cls, 3, k)});
      chk($sformatf("wc3 k%0d", k), {32'd0, wc3},
          {32'd0, (cls == 2 && k >= 5) ? new_wc : wc_m3});
      // scramble latched inputs; optionally re-pulse start while busy
      store_type = hold ? 2'b00 : 2'($urandom);
      addr_lo    = 2'($urandom);
      b_data     = $urandom;
      start1     = hold && (k < n1);
      start3     = hold && (k < n3);
    end
    if (cls == 2) begin
      wc_m1 = new_wc;
      wc_m3 = new_wc;
    end
  endtask

  initial begin
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    store_type = '0; addr_lo = '0; b_data = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ctl1", {58'd0, rd1, wr1, wdc1, busy1, done1, err1}, 64'd0);
    chk("rst ctl3", {58'd0, rd3, wr3, wdc3, busy3, done3, err3}, 64'd0);
    chk("rst wc1", {32'd0, wc1}, 64'd0);
    chk("rst wc3", {32'd0, wc3}, 64'd0);
    reset = 1'b1;

    run_op(2'b00, 2'd0, 32'hDEADBEEF, 32'h0, 1'b0);
    run_op(2'b10, 2'd2, 32'h000000AB, 32'h11223344, 1'b0);
    run_op(2'b01, 2'd2, 32'h0000BEEF, 32'h11223344, 1'b0);
    run_op(2'b01, 2'd1, 32'h0000BEEF, 32'h11223344, 1'b0);
    run_op(2'b11, 2'd0, 32'h12345678, 32'hCAFEF00D, 1'b0);
    run_op(2'b10, 2'd1, 32'h000000CD, 32'hAABBCCDD, 1'b1);
    run_op(2'b00, 2'd3, 32'h0BADF00D, 32'h0, 1'b1);

    // reset during READ abandons the store
    @(negedge clk);
    start1 = 1'b1; start3 = 1'b1;
    store_type = 2'b10; addr_lo = 2'd1; b_data = 32'h55; mem_rdata = 32'h99887766;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("mrst ctl1 k%0d", k), {58'd0, rd1, wr1, wdc1, busy1, done1, err1}, 64'd0);
      chk($sformatf("mrst ctl3 k%0d", k), {58'd0, rd3, wr3, wdc3, busy3, done3, err3}, 64'd0);
      chk($sformatf("mrst wc1 k%0d", k), {32'd0, wc1}, 64'd0);
      chk($sformatf("mrst wc3 k%0d", k), {32'd0, wc3}, 64'd0);
      reset = 1'b1;
    end
    wc_m1 = '0;
    wc_m3 = '0;
    run_op(2'b00, 2'd0, 32'h13579BDF, 32'h0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_op(2'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
